// File: rtl/ecc_mon_pkg.sv
// Shared encodings for the ECC error monitor: error types, FSM states and
// the priority encoder that turns checker flags into an error type.
package ecc_mon_pkg;

  localparam int unsigned ERR_TYPE_WIDTH = 2;

  localparam logic [ERR_TYPE_WIDTH-1:0] ERR_NONE  = 2'b00;
  localparam logic [ERR_TYPE_WIDTH-1:0] ERR_SBIT  = 2'b01;
  localparam logic [ERR_TYPE_WIDTH-1:0] ERR_DBIT  = 2'b10;
  localparam logic [ERR_TYPE_WIDTH-1:0] ERR_FAULT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // nothing captured
    ST_LOG  = 2'b01,  // first error held, interrupt not raised
    ST_IRQ  = 2'b10   // interrupt raised
  } mon_state_e;

  // Priority fault > dbit > sbit.
  function automatic logic [ERR_TYPE_WIDTH-1:0] err_type_f(input logic sbit,
                                                           input logic dbit,
                                                           input logic fault);
    if (fault)     return ERR_FAULT;
    else if (dbit) return ERR_DBIT;
    else if (sbit) return ERR_SBIT;
    else           return ERR_NONE;
  endfunction

endpackage

// File: rtl/ecc_sat_cnt.sv
// Saturating event counter with synchronous clear; clear coincident with an
// increment leaves the counter at 1.
// Ports: clk, rst_n (async active-low), inc, clr -> cnt (registered),
//        cnt_nxt_c (combinational next value, for threshold lookahead).
module ecc_sat_cnt #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [CNT_WIDTH-1:0] cnt_nxt_c
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Next-value: clear wins but still counts a same-cycle increment.
  always_comb begin
    cnt_nxt_c = cnt;
    if (clr) begin
      cnt_nxt_c = CNT_WIDTH'(inc);
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt_nxt_c = cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt_c;
  end

endmodule

// File: rtl/ecc_133_err_monitor.sv
// ECC error monitor: counts single/double-bit errors and checker faults,
// captures the first error, raises a level interrupt and (optionally) issues
// scrub requests for correctable errors.
// Ports: clk, rst_n; rd_vld/rd_addr/sbit_err/dbit_err/ecc_fault from the ECC
//        checker; irq_thresh, irq_clr, cnt_clr control; sbit_cnt/dbit_cnt/
//        fault_cnt counters; first_err_addr/first_err_type capture; err_irq;
//        scrub_req/scrub_addr/scrub_ack handshake and scrub_drop_cnt.
// Build option: define ECC_ERR_SCRUB_EN to enable the scrub request logic;
//               otherwise the scrub outputs are tied to 0 and scrub_ack ignored.
module ecc_133_err_monitor
  import ecc_mon_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  sbit_err,
  input  logic                  dbit_err,
  input  logic                  ecc_fault,
  input  logic [CNT_WIDTH-1:0]  irq_thresh,
  input  logic                  irq_clr,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [1:0]            first_err_type,
  output logic                  err_irq,
  output logic                  scrub_req,
  output logic [ADDR_WIDTH-1:0] scrub_addr,
  input  logic                  scrub_ack,
  output logic [CNT_WIDTH-1:0]  scrub_drop_cnt
);

  // Qualified events: flags only count alongside rd_vld.
  logic sbit_ev, dbit_ev, fault_ev, any_ev, thresh_hit;
  logic [CNT_WIDTH-1:0] sbit_nxt;
  logic [CNT_WIDTH-1:0] unused_dbit_nxt, unused_fault_nxt;
  logic [1:0] ev_type;

  assign sbit_ev  = rd_vld & sbit_err;
  assign dbit_ev  = rd_vld & dbit_err;
  assign fault_ev = rd_vld & ecc_fault;
  assign any_ev   = sbit_ev | dbit_ev | fault_ev;
  assign ev_type  = err_type_f(sbit_ev, dbit_ev, fault_ev);

  ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_sbit_cnt (
    .clk(clk), .rst_n(rst_n), .inc(sbit_ev), .clr(cnt_clr),
    .cnt(sbit_cnt), .cnt_nxt_c(sbit_nxt)
  );
  ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_dbit_cnt (
    .clk(clk), .rst_n(rst_n), .inc(dbit_ev), .clr(cnt_clr),
    .cnt(dbit_cnt), .cnt_nxt_c(unused_dbit_nxt)
  );
  ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_fault_cnt (
    .clk(clk), .rst_n(rst_n), .inc(fault_ev), .clr(cnt_clr),
    .cnt(fault_cnt), .cnt_nxt_c(unused_fault_nxt)
  );

  // Threshold is checked against the counter's next value so the interrupt
  // follows in the same cycle as the counter update.
  assign thresh_hit = (irq_thresh != '0) && (sbit_nxt >= irq_thresh);

  mon_state_e state_q, state_d, base_state;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [1:0]            type_d;

  // Next-state and capture; irq_clr first rewinds to an empty IDLE so a
  // coincident event is captured as a fresh first error.
  always_comb begin
    base_state = irq_clr ? ST_IDLE : state_q;
    state_d    = base_state;
    addr_d     = irq_clr ? '0 : first_err_addr;
    type_d     = irq_clr ? ERR_NONE : first_err_type;
    case (base_state)
      ST_IDLE: begin
        if (any_ev) begin
          addr_d  = rd_addr;
          type_d  = ev_type;
          state_d = (dbit_ev || fault_ev || thresh_hit) ? ST_IRQ : ST_LOG;
        end
      end
      ST_LOG: begin
        if (dbit_ev || fault_ev || thresh_hit) state_d = ST_IRQ;
      end
      ST_IRQ:  state_d = ST_IRQ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      first_err_addr <= '0;
      first_err_type <= ERR_NONE;
      err_irq        <= 1'b0;
    end else begin
      state_q        <= state_d;
      first_err_addr <= addr_d;
      first_err_type <= type_d;
      err_irq        <= (state_d == ST_IRQ);
    end
  end

`ifdef ECC_ERR_SCRUB_EN
  // Scrub only correctable words; an ack frees the slot for a same-cycle request.
  logic sbit_only, scrub_free, scrub_drop;
  logic [CNT_WIDTH-1:0] unused_drop_nxt;

  assign sbit_only  = sbit_ev & ~dbit_ev & ~fault_ev;
  assign scrub_free = ~scrub_req | scrub_ack;
  assign scrub_drop = sbit_only & scrub_req & ~scrub_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scrub_req  <= 1'b0;
      scrub_addr <= '0;
    end else if (sbit_only && scrub_free) begin
      scrub_req  <= 1'b1;
      scrub_addr <= rd_addr;
    end else if (scrub_ack) begin
      scrub_req  <= 1'b0;
    end
  end

  ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk(clk), .rst_n(rst_n), .inc(scrub_drop), .clr(cnt_clr),
    .cnt(scrub_drop_cnt), .cnt_nxt_c(unused_drop_nxt)
  );
`else
  logic unused_scrub_ack;
  assign unused_scrub_ack = scrub_ack;
  assign scrub_req        = 1'b0;
  assign scrub_addr       = '0;
  assign scrub_drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_ecc_133_err_monitor.sv
// Directed self-checking bench for ecc_133_err_monitor (CNT_WIDTH=4 so that
// saturation is reachable). Scrub expectations follow ECC_ERR_SCRUB_EN.
module tb_ecc_133_err_monitor;

  localparam int unsigned AW = 8;
  localparam int unsigned CW = 4;
`ifdef ECC_ERR_SCRUB_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rd_vld = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          sbit_err = 1'b0, dbit_err = 1'b0, ecc_fault = 1'b0;
  logic [CW-1:0] irq_thresh = '0;
  logic          irq_clr = 1'b0, cnt_clr = 1'b0, scrub_ack = 1'b0;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt, scrub_drop_cnt;
  logic [AW-1:0] first_err_addr, scrub_addr;
  logic [1:0]    first_err_type;
  logic          err_irq, scrub_req;

  int checks = 0;
  int failures = 0;

  ecc_133_err_monitor #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rd_vld(rd_vld), .rd_addr(rd_addr),
    .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault),
    .irq_thresh(irq_thresh), .irq_clr(irq_clr), .cnt_clr(cnt_clr),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
    .first_err_addr(first_err_addr), .first_err_type(first_err_type),
    .err_irq(err_irq), .scrub_req(scrub_req), .scrub_addr(scrub_addr),
    .scrub_ack(scrub_ack), .scrub_drop_cnt(scrub_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a,
                       input logic s, input logic d, input logic f);
    rd_vld = v; rd_addr = a; sbit_err = s; dbit_err = d; ecc_fault = f;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    irq_clr = 1'b0; cnt_clr = 1'b0; scrub_ack = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    irq_thresh = '0;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    checks++; if (sbit_cnt !== 4'd0) begin failures++; $display("FAIL rst_sbit_cnt got=%0h exp=0", sbit_cnt); end
    checks++; if (dbit_cnt !== 4'd0) begin failures++; $display("FAIL rst_dbit_cnt got=%0h exp=0", dbit_cnt); end
    checks++; if (fault_cnt !== 4'd0) begin failures++; $display("FAIL rst_fault_cnt got=%0h exp=0", fault_cnt); end
    checks++; if (first_err_addr !== 8'h00) begin failures++; $display("FAIL rst_first_addr got=%0h exp=0", first_err_addr); end
    checks++; if (first_err_type !== 2'b00) begin failures++; $display("FAIL rst_first_type got=%0h exp=0", first_err_type); end
    checks++; if (err_irq !== 1'b0) begin failures++; $display("FAIL rst_err_irq got=%0h exp=0", err_irq); end
    checks++; if (scrub_req !== 1'b0) begin failures++; $display("FAIL rst_scrub_req got=%0h exp=0", scrub_req); end
    checks++; if (scrub_addr !== 8'h00) begin failures++; $display("FAIL rst_scrub_addr got=%0h exp=0", scrub_addr); end
    checks++; if (scrub_drop_cnt !== 4'd0) begin failures++; $display("FAIL rst_drop_cnt got=%0h exp=0", scrub_drop_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_first_sbit();
    test_reset();
    irq_thresh = 4'd3;
    drive(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    checks++; if (sbit_cnt !== 4'd1) begin failures++; $display("FAIL s1_sbit_cnt got=%0h exp=1", sbit_cnt); end
    checks++; if (err_irq !== 1'b0) begin failures++; $display("FAIL s1_err_irq got=%0h exp=0", err_irq); end
    checks++; if (first_err_addr !== 8'h12) begin failures++; $display("FAIL s1_first_addr got=%0h exp=12", first_err_addr); end
    checks++; if (first_err_type !== 2'b01) begin failures++; $display("FAIL s1_first_type got=%0h exp=1", first_err_type); end
    checks++; if (scrub_req !== SC) begin failures++; $display("FAIL s1_scrub_req got=%0h exp=%0h", scrub_req, SC); end
    checks++; if (scrub_addr !== (SC ? 8'h12 : 8'h00)) begin failures++; $display("FAIL s1_scrub_addr got=%0h exp=%0h", scrub_addr, SC ? 8'h12 : 8'h00); end
  endtask

  task automatic test_thresh_irq();
    test_reset();
    irq_thresh = 4'd3;
    drive(1'b1, 8'h12, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h20, 1'b1, 1'b0, 1'b0); tick();
    checks++; if (err_irq !== 1'b0) begin failures++; $display("FAIL th_irq_early got=%0h exp=0", err_irq); end
    drive(1'b1, 8'h30, 1'b1, 1'b0, 1'b0); tick();
    idle();
    checks++; if (err_irq !== 1'b1) begin failures++; $display("FAIL th_err_irq got=%0h exp=1", err_irq); end
    checks++; if (sbit_cnt !== 4'd3) begin failures++; $display("FAIL th_sbit_cnt got=%0h exp=3", sbit_cnt); end
    checks++; if (first_err_addr !== 8'h12) begin failures++; $display("FAIL th_first_addr got=%0h exp=12", first_err_addr); end
    checks++; if (first_err_type !== 2'b01) begin failures++; $display("FAIL th_first_type got=%0h exp=1", first_err_type); end
    checks++; if (scrub_drop_cnt !== (SC ? 4'd2 : 4'd0)) begin failures++; $display("FAIL th_drop_cnt got=%0h exp=%0h", scrub_drop_cnt, SC ? 4'd2 : 4'd0); end
    checks++; if (scrub_addr !== (SC ? 8'h12 : 8'h00)) begin failures++; $display("FAIL th_scrub_addr got=%0h exp=%0h", scrub_addr, SC ? 8'h12 : 8'h00); end
  endtask

  task automatic test_dbit_fault();
    test_reset();
    irq_thresh = 4'd3;
    drive(1'b1, 8'h44, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    checks++; if (err_irq !== 1'b1) begin failures++; $display("FAIL df_err_irq got=%0h exp=1", err_irq); end
    checks++; if (first_err_type !== 2'b11) begin failures++; $display("FAIL df_first_type got=%0h exp=3", first_err_type); end
    checks++; if (first_err_addr !== 8'h44) begin failures++; $display("FAIL df_first_addr got=%0h exp=44", first_err_addr); end
    checks++; if (dbit_cnt !== 4'd1) begin failures++; $display("FAIL df_dbit_cnt got=%0h exp=1", dbit_cnt); end
    checks++; if (fault_cnt !== 4'd1) begin failures++; $display("FAIL df_fault_cnt got=%0h exp=1", fault_cnt); end
    checks++; if (sbit_cnt !== 4'd0) begin failures++; $display("FAIL df_sbit_cnt got=%0h exp=0", sbit_cnt); end
    checks++; if (scrub_req !== 1'b0) begin failures++; $display("FAIL df_scrub_req got=%0h exp=0", scrub_req); end
  endtask

  // Runs straight after test_dbit_fault, so the monitor starts in IRQ.
  task automatic test_clr_with_event();
    irq_thresh = 4'd0;
    irq_clr = 1'b1;
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    checks++; if (err_irq !== 1'b0) begin failures++; $display("FAIL ce_err_irq got=%0h exp=0", err_irq); end
    checks++; if (first_err_addr !== 8'h55) begin failures++; $display("FAIL ce_first_addr got=%0h exp=55", first_err_addr); end
    checks++; if (first_err_type !== 2'b01) begin failures++; $display("FAIL ce_first_type got=%0h exp=1", first_err_type); end
    checks++; if (scrub_req !== SC) begin failures++; $display("FAIL ce_scrub_req got=%0h exp=%0h", scrub_req, SC); end
    irq_clr = 1'b1;
    tick();
    idle();
    checks++; if (first_err_type !== 2'b00) begin failures++; $display("FAIL cl_first_type got=%0h exp=0", first_err_type); end
    checks++; if (first_err_addr !== 8'h00) begin failures++; $display("FAIL cl_first_addr got=%0h exp=0", first_err_addr); end
  endtask

  task automatic test_log_paths();
    test_reset();
    irq_thresh = 4'd0;
    drive(1'b1, 8'h21, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h22, 1'b0, 1'b1, 1'b0); tick();
    idle();
    checks++; if (err_irq !== 1'b1) begin failures++; $display("FAIL lg_dbit_irq got=%0h exp=1", err_irq); end
    checks++; if (first_err_addr !== 8'h21) begin failures++; $display("FAIL lg_first_addr got=%0h exp=21", first_err_addr); end
    checks++; if (first_err_type !== 2'b01) begin failures++; $display("FAIL lg_first_type got=%0h exp=1", first_err_type); end
    test_reset();
    irq_thresh = 4'd1;
    drive(1'b1, 8'h31, 1'b1, 1'b0, 1'b0); tick();
    idle();
    checks++; if (err_irq !== 1'b1) begin failures++; $display("FAIL lg_direct_irq got=%0h exp=1", err_irq); end
    checks++; if (first_err_addr !== 8'h31) begin failures++; $display("FAIL lg_direct_addr got=%0h exp=31", first_err_addr); end
  endtask

  task automatic test_saturation();
    test_reset();
    irq_thresh = 4'd0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    checks++; if (sbit_cnt !== 4'hf) begin failures++; $display("FAIL sat_sbit_15 got=%0h exp=f", sbit_cnt); end
    checks++; if (scrub_drop_cnt !== (SC ? 4'd14 : 4'd0)) begin failures++; $display("FAIL sat_drop_14 got=%0h exp=%0h", scrub_drop_cnt, SC ? 4'd14 : 4'd0); end
    tick();
    checks++; if (sbit_cnt !== 4'hf) begin failures++; $display("FAIL sat_sbit_hold got=%0h exp=f", sbit_cnt); end
    checks++; if (scrub_drop_cnt !== (SC ? 4'hf : 4'd0)) begin failures++; $display("FAIL sat_drop_15 got=%0h exp=%0h", scrub_drop_cnt, SC ? 4'hf : 4'd0); end
    checks++; if (err_irq !== 1'b0) begin failures++; $display("FAIL sat_thresh0_irq got=%0h exp=0", err_irq); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (sbit_cnt !== 4'd1) begin failures++; $display("FAIL sat_clr_inc got=%0h exp=1", sbit_cnt); end
    checks++; if (scrub_drop_cnt !== (SC ? 4'd1 : 4'd0)) begin failures++; $display("FAIL sat_drop_clr got=%0h exp=%0h", scrub_drop_cnt, SC ? 4'd1 : 4'd0); end
    drive(1'b0, 8'h99, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    checks++; if (sbit_cnt !== 4'd1) begin failures++; $display("FAIL ign_sbit_cnt got=%0h exp=1", sbit_cnt); end
    checks++; if (dbit_cnt !== 4'd0) begin failures++; $display("FAIL ign_dbit_cnt got=%0h exp=0", dbit_cnt); end
    cnt_clr = 1'b1;
    tick();
    idle();
    checks++; if (sbit_cnt !== 4'd0) begin failures++; $display("FAIL clr_sbit_cnt got=%0h exp=0", sbit_cnt); end
  endtask

  task automatic test_scrub_ack();
    test_reset();
    irq_thresh = 4'd0;
    drive(1'b1, 8'h10, 1'b1, 1'b0, 1'b0); tick();
    checks++; if (scrub_addr !== (SC ? 8'h10 : 8'h00)) begin failures++; $display("FAIL sa_first_addr got=%0h exp=%0h", scrub_addr, SC ? 8'h10 : 8'h00); end
    drive(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
    scrub_ack = 1'b1;
    tick();
    checks++; if (scrub_req !== SC) begin failures++; $display("FAIL sa_req_kept got=%0h exp=%0h", scrub_req, SC); end
    checks++; if (scrub_addr !== (SC ? 8'h66 : 8'h00)) begin failures++; $display("FAIL sa_new_addr got=%0h exp=%0h", scrub_addr, SC ? 8'h66 : 8'h00); end
    checks++; if (scrub_drop_cnt !== 4'd0) begin failures++; $display("FAIL sa_no_drop got=%0h exp=0", scrub_drop_cnt); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (scrub_req !== 1'b0) begin failures++; $display("FAIL sa_req_done got=%0h exp=0", scrub_req); end
    tick();
    checks++; if (scrub_req !== 1'b0) begin failures++; $display("FAIL sa_ack_ignored got=%0h exp=0", scrub_req); end
    scrub_ack = 1'b0;
    drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0); tick();
    idle();
    tick();
    checks++; if (scrub_req !== SC) begin failures++; $display("FAIL sa_req_hold got=%0h exp=%0h", scrub_req, SC); end
    checks++; if (scrub_addr !== (SC ? 8'h77 : 8'h00)) begin failures++; $display("FAIL sa_addr_hold got=%0h exp=%0h", scrub_addr, SC ? 8'h77 : 8'h00); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (scrub_req !== 1'b0) begin failures++; $display("FAIL sa_async_rst_req got=%0h exp=0", scrub_req); end
    checks++; if (scrub_addr !== 8'h00) begin failures++; $display("FAIL sa_async_rst_addr got=%0h exp=0", scrub_addr); end
    checks++; if (first_err_type !== 2'b00) begin failures++; $display("FAIL sa_async_rst_type got=%0h exp=0", first_err_type); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_sbit();
    test_thresh_irq();
    test_dbit_fault();
    test_clr_with_event();
    test_log_paths();
    test_saturation();
    test_scrub_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
